// File: rtl/sram_req_sched_pkg.sv
// Shared constants, request classification and credit arithmetic for the
// SRAM request scheduler and its response FIFO.
package sram_req_sched_pkg;

  localparam int RSP_FIFO_DEPTH = 2;
  localparam int RSP_PTR_W      = 1;
  localparam int RSP_OCC_W      = 2;

  // Credit sums need one bit more than occupancy so a full FIFO plus an
  // in-flight read never wraps.
  localparam logic [RSP_OCC_W:0] RSP_CREDIT_LIMIT = (RSP_OCC_W + 1)'(RSP_FIFO_DEPTH);

  // The SRAM drives this on DOUT after a write; a capture of it means the
  // read data was sampled a cycle too late.
  localparam int MAX_DW = 1024;
  localparam logic [MAX_DW-1:0] SRAM_UNCERTAIN_PAT = {(MAX_DW / 2){2'b01}};

  typedef enum logic [1:0] {
    REQ_IDLE,
    REQ_READ,
    REQ_WRITE
  } req_kind_e;

  function automatic req_kind_e classify_req(input logic accepted, input logic any_byte);
    if (!accepted) return REQ_IDLE;
    return any_byte ? REQ_WRITE : REQ_READ;
  endfunction

  function automatic logic [RSP_OCC_W:0] credit_use(input logic [RSP_OCC_W-1:0] occ,
                                                    input logic inflight,
                                                    input logic pop);
    return {1'b0, occ} + {{RSP_OCC_W{1'b0}}, inflight} - {{RSP_OCC_W{1'b0}}, pop};
  endfunction

endpackage

// File: rtl/sram_req_sched_if.sv
// Request, response and SRAM-side signals of the scheduler. slave is the
// scheduler's view; master is the surrounding system (requester, sink, SRAM).
interface sram_req_sched_if #(
  parameter int P_DW = 6,
  parameter int AW   = 6
);
  localparam int DW = 1 << P_DW;
  localparam int BW = DW / 8;

  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [BW-1:0] req_we;
  logic [DW-1:0] req_wdat;

  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_rdat;

  logic [AW-1:0] sram_addr;
  logic          sram_re;
  logic [BW-1:0] sram_we;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  modport slave (
    input  req_valid, req_addr, req_we, req_wdat, rsp_ready, sram_dout,
    output req_ready, rsp_valid, rsp_rdat, sram_addr, sram_re, sram_we, sram_din
  );

  modport master (
    output req_valid, req_addr, req_we, req_wdat, rsp_ready, sram_dout,
    input  req_ready, rsp_valid, rsp_rdat, sram_addr, sram_re, sram_we, sram_din
  );

endinterface

// File: rtl/sram_rsp_fifo.sv
// Two-entry response FIFO: async-reset pointers and occupancy, unreset data
// slots, head presented combinationally.
module sram_rsp_fifo
  import sram_req_sched_pkg::*;
#(
  parameter int W = 64
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 push,
  input  logic [W-1:0]         din,
  input  logic                 pop,
  output logic [W-1:0]         head,
  output logic [RSP_OCC_W-1:0] occ
);

  logic [W-1:0]         slot [RSP_FIFO_DEPTH];
  logic [RSP_PTR_W-1:0] wr_ptr;
  logic [RSP_PTR_W-1:0] rd_ptr;

  // Pointers are exactly log2(depth) wide, so increments wrap modulo 2.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + RSP_PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + RSP_PTR_W'(1);
      case ({push, pop})
        2'b10:   occ <= occ + RSP_OCC_W'(1);
        2'b01:   occ <= occ - RSP_OCC_W'(1);
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (push) slot[wr_ptr] <= din;
  end

  assign head = slot[rd_ptr];

  a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
    !(push && !pop && occ == RSP_OCC_W'(RSP_FIFO_DEPTH)));
  a_no_underflow: assert property (@(posedge CLK) disable iff (RST)
    !(pop && occ == '0));

endmodule

// File: rtl/sram_req_sched.sv
// Drives a single-port byte-enable SRAM from a valid/ready request channel and
// returns read data via a 2-entry buffer. SRAM_REQ_SCHED_BYPASS_EN adds a 1-cycle read path.
module sram_req_sched
  import sram_req_sched_pkg::*;
#(
  parameter int P_DW = 6,
  parameter int AW   = 6
) (
  input logic             CLK,
  input logic             RST,
  sram_req_sched_if.slave bus
);

  localparam int DW = 1 << P_DW;
  localparam int BW = DW / 8;

  req_kind_e            kind;
  logic                 rd_issue;
  logic                 inflight_ff;
  logic                 pop;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [RSP_OCC_W-1:0] occ;
  logic [DW-1:0]        fifo_head;

  // Nothing reaches the SRAM while reset is held, even though req_ready is 1.
  assign kind     = classify_req(bus.req_valid & bus.req_ready & ~RST, |bus.req_we);
  assign rd_issue = (kind == REQ_READ);

  assign bus.sram_addr = bus.req_addr[AW-1:0];
  assign bus.sram_din  = bus.req_wdat;
  assign bus.sram_re   = rd_issue;
  assign bus.sram_we   = bus.req_we & {BW{kind == REQ_WRITE}};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) inflight_ff <= 1'b0;
    else     inflight_ff <= rd_issue;
  end

  assign pop = bus.rsp_valid & bus.rsp_ready;

`ifdef SRAM_REQ_SCHED_BYPASS_EN
  logic bypass_hit;

  // With nothing queued, the read returning this cycle goes straight out;
  // it only lands in the FIFO if the sink stalls.
  assign bypass_hit    = inflight_ff & (occ == '0);
  assign bus.rsp_valid = (occ != '0) | bypass_hit;
  assign bus.rsp_rdat  = bypass_hit ? bus.sram_dout : fifo_head;
  assign fifo_push     = inflight_ff & ~(bypass_hit & bus.rsp_ready);
  assign fifo_pop      = pop & ~bypass_hit;
`else
  assign bus.rsp_valid = (occ != '0);
  assign bus.rsp_rdat  = fifo_head;
  assign fifo_push     = inflight_ff;
  assign fifo_pop      = pop;
`endif

  // Buffered plus in-flight reads, less the one leaving now, must leave room
  // for whatever gets accepted this cycle; writes share the same credit.
  assign bus.req_ready = credit_use(occ, inflight_ff, pop) < RSP_CREDIT_LIMIT;

  sram_rsp_fifo #(
    .W(DW)
  ) u_rsp_fifo (
    .CLK (CLK),
    .RST (RST),
    .push(fifo_push),
    .din (bus.sram_dout),
    .pop (fifo_pop),
    .head(fifo_head),
    .occ (occ)
  );

  a_one_sram_op: assert property (@(posedge CLK) disable iff (RST)
    !(bus.sram_re && bus.sram_we != '0));

endmodule

// File: tb/tb_sram_req_sched.sv
// Randomised scoreboard bench for sram_req_sched with a behavioural SRAM and a
// shadow-memory reference model.
module tb_sram_req_sched;
  import sram_req_sched_pkg::*;

  localparam int P_DW  = 6;
  localparam int AW    = 6;
  localparam int DW    = 1 << P_DW;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 1 << AW;
`ifdef SRAM_REQ_SCHED_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif
  localparam logic [DW-1:0] UNCERTAIN = SRAM_UNCERTAIN_PAT[DW-1:0];

  typedef struct {
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;

  sram_req_sched_if #(.P_DW(P_DW), .AW(AW)) bus ();

  sram_req_sched #(.P_DW(P_DW), .AW(AW)) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  logic [DW-1:0] sram_mem [DEPTH];
  logic [DW-1:0] shadow   [DEPTH];
  exp_t          expq[$];
  int            cycle = 0;
  int            vectors = 0;
  int            miscompares = 0;
  int            rsp_count = 0;
  logic [DW-1:0] last_rsp = '0;

  always @(posedge CLK) cycle <= cycle + 1;

  // Behavioural SRAM: 1-cycle read latency, DOUT turns uncertain after a write.
  always @(posedge CLK) begin
    if (bus.sram_we != '0) begin
      for (int b = 0; b < BW; b++)
        if (bus.sram_we[b]) sram_mem[bus.sram_addr][b*8 +: 8] <= bus.sram_din[b*8 +: 8];
      bus.sram_dout <= UNCERTAIN;
    end else if (bus.sram_re) begin
      bus.sram_dout <= sram_mem[bus.sram_addr];
    end
  end

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  // Called at posedge+1; presents one request, decides acceptance at the
  // negedge, and updates the reference model on the following edge.
  task automatic applyStimulus(input bit valid, input logic [AW-1:0] addr,
                               input logic [BW-1:0] we, input logic [DW-1:0] data,
                               output bit acc);
    exp_t e;
    int   acc_cyc;
    bus.req_valid = valid;
    bus.req_addr  = addr;
    bus.req_we    = we;
    bus.req_wdat  = data;
    @(negedge CLK);
    acc     = valid && (bus.req_ready === 1'b1) && !RST;
    acc_cyc = cycle;
    @(posedge CLK);
    if (acc) begin
      if (we == '0) begin
        e.data = shadow[addr];
        e.cyc  = acc_cyc;
        expq.push_back(e);
      end else begin
        for (int b = 0; b < BW; b++)
          if (we[b]) shadow[addr][b*8 +: 8] = data[b*8 +: 8];
      end
    end
    #1;
  endtask

  task automatic offer(input logic [AW-1:0] addr, input logic [BW-1:0] we,
                       input logic [DW-1:0] data);
    bit a;
    a = 1'b0;
    for (int t = 0; t < 8 && !a; t++) applyStimulus(1'b1, addr, we, data, a);
    checkOutput("offer_accept", DW'(a), 1);
  endtask

  task automatic drain(input int maxc);
    bit a;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < maxc && expq.size() != 0; i++) applyStimulus(1'b0, '0, '0, '0, a);
    checkOutput("drain_empty", DW'(expq.size()), 0);
  endtask

  // Monitor: every cycle out of reset, rsp_valid and req_ready must match the
  // outstanding-read queue, and each handshaken response must match its head.
  logic mon_pop;
  logic mon_exp_valid;
  exp_t mon_e;
  initial begin
    forever begin
      @(negedge CLK);
      if (!RST) begin
        mon_pop       = bus.rsp_valid & bus.rsp_ready;
        mon_exp_valid = (expq.size() != 0) && ((cycle - expq[0].cyc) >= LAT);
        checkOutput("rsp_valid", DW'(bus.rsp_valid), DW'(mon_exp_valid));
        checkOutput("req_ready", DW'(bus.req_ready),
                    DW'((expq.size() - int'(mon_pop)) < 2));
        if (mon_pop && expq.size() != 0) begin
          mon_e = expq.pop_front();
          checkOutput("rsp_rdat", bus.rsp_rdat, mon_e.data);
          last_rsp = bus.rsp_rdat;
          rsp_count++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit            acc;
    int            accepts;
    int            nxt;
    int            c0;
    bit            p_valid;
    logic [AW-1:0] p_addr;
    logic [BW-1:0] p_we;
    logic [DW-1:0] p_data;

    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_we    = '0;
    bus.req_wdat  = '0;
    bus.rsp_ready = 1'b1;
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    checkOutput("reset_req_ready", DW'(bus.req_ready), 1);
    checkOutput("reset_rsp_valid", DW'(bus.rsp_valid), 0);
    checkOutput("reset_sram_re", DW'(bus.sram_re), 0);
    checkOutput("reset_sram_we", DW'(bus.sram_we), 0);
    RST = 1'b0;

    for (int a = 0; a < DEPTH; a++) offer(AW'(a), '1, {$urandom, $urandom});

    $display("[TB] write then read");
    offer(AW'(5), 8'hFF, 64'hDEADBEEF_CAFEF00D);
    offer(AW'(5), 8'h00, '0);
    drain(20);
    checkOutput("wr_rd_data", last_rsp, 64'hDEADBEEF_CAFEF00D);

    $display("[TB] byte mask");
    offer(AW'(3), 8'hFF, {16{4'h1}});
    offer(AW'(3), 8'h0F, {16{4'hA}});
    offer(AW'(3), 8'h00, '0);
    drain(20);
    checkOutput("byte_mask", last_rsp, 64'h11111111_AAAAAAAA);

    $display("[TB] read followed by write");
    offer(AW'(3), 8'h00, '0);
    offer(AW'(4), 8'hFF, {$urandom, $urandom});
    drain(20);
    checkOutput("rd_wr_data", last_rsp, 64'h11111111_AAAAAAAA);
    checkOutput("rd_wr_not_uncertain", DW'(last_rsp == UNCERTAIN), 0);

    $display("[TB] backpressure");
    bus.rsp_ready = 1'b0;
    accepts = 0;
    nxt = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(nxt < 4, AW'(nxt), '0, '0, acc);
      if (acc) begin
        accepts++;
        nxt++;
      end
    end
    checkOutput("bp_accepted", DW'(accepts), 2);
    checkOutput("bp_req_ready_low", DW'(bus.req_ready), 0);
    c0 = rsp_count;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 20 && nxt < 4; i++) begin
      applyStimulus(1'b1, AW'(nxt), '0, '0, acc);
      if (acc) nxt++;
    end
    checkOutput("bp_all_issued", DW'(nxt), 4);
    drain(20);
    checkOutput("bp_rsp_count", DW'(rsp_count - c0), 4);

    $display("[TB] streaming");
    c0 = rsp_count;
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, AW'(i * 3), '0, '0, acc);
      checkOutput("stream_ready", DW'(acc), 1);
    end
    drain(20);
    checkOutput("stream_rsp_count", DW'(rsp_count - c0), 16);

    $display("[TB] reset mid-operation");
    offer(AW'(7), 8'h00, '0);
    RST = 1'b1;
    expq.delete();
    #1;
    checkOutput("rst_rsp_valid", DW'(bus.rsp_valid), 0);
    checkOutput("rst_req_ready", DW'(bus.req_ready), 1);
    checkOutput("rst_sram_re", DW'(bus.sram_re), 0);
    checkOutput("rst_sram_we", DW'(bus.sram_we), 0);
    bus.req_valid = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    c0 = rsp_count;
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, '0, '0, '0, acc);
    checkOutput("rst_no_rsp", DW'(rsp_count - c0), 0);
    checkOutput("rst_ready_after", DW'(bus.req_ready), 1);

    $display("[TB] random traffic");
    p_valid = 1'b0;
    p_addr  = '0;
    p_we    = '0;
    p_data  = '0;
    acc     = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if (!p_valid || acc) begin
        p_valid = ($urandom_range(3) != 0);
        p_addr  = AW'($urandom_range(DEPTH - 1));
        p_we    = ($urandom_range(1) == 1) ? BW'($urandom) : '0;
        p_data  = {$urandom, $urandom};
      end
      bus.rsp_ready = ($urandom_range(3) != 0);
      applyStimulus(p_valid, p_addr, p_we, p_data, acc);
    end
    drain(20);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
